// File: rtl/vga_blit_scheduler_if.sv
// Requester / ROM / VGA-adapter signal bundle for vga_blit_scheduler.
// The scheduler sits on the slave modport; the requesters, colour ROM and
// VGA adapter side (or a testbench standing in for them) use master.
interface vga_blit_scheduler_if #(
  parameter int ADDR_W = 18
);
  // Requester side: three packed job descriptors.
  logic [2:0]          req;
  logic [23:0]         req_x;
  logic [20:0]         req_y;
  logic [23:0]         req_w;
  logic [20:0]         req_h;
  logic [3*ADDR_W-1:0] req_base;
  logic [2:0]          req_key;
  logic [2:0]          ack;
  logic [2:0]          done;
  logic                busy;
  // Colour ROM side.
  logic [ADDR_W-1:0]   rom_addr;
  logic [23:0]         rom_q;
  // VGA adapter side.
  logic [7:0]          x_out;
  logic [6:0]          y_out;
  logic [23:0]         colour_out;
  logic                draw;

  modport slave (
    input  req, req_x, req_y, req_w, req_h, req_base, req_key, rom_q,
    output ack, done, busy, rom_addr, x_out, y_out, colour_out, draw
  );

  modport master (
    output req, req_x, req_y, req_w, req_h, req_base, req_key, rom_q,
    input  ack, done, busy, rom_addr, x_out, y_out, colour_out, draw
  );
endinterface

// File: rtl/vga_blit_scheduler.sv
// Round-robin rectangle-blit scheduler for a single VGA pixel-write port.
// Latches the winning job, walks it in raster order issuing one colour-ROM
// address per cycle, and re-aligns coordinates with the ROM's registered
// output before driving the pixel write strobe.
module vga_blit_scheduler #(
  parameter int          ROM_LATENCY = 1,
  parameter int          SCREEN_W    = 160,
  parameter int          SCREEN_H    = 120,
  parameter int          ADDR_W      = 18,
  parameter logic [23:0] KEY_COLOUR  = 24'hFF00FF
) (
  input logic                clk,
  input logic                resetn,
  vga_blit_scheduler_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WALK, DRAIN, FIN} state_t;

  // One in-flight pixel waiting for its ROM word.
  typedef struct packed {
    logic       valid;
    logic [8:0] x;
    logic [7:0] y;
  } pix_t;

  state_t            state_q, state_d;
  logic [1:0]        ptr_q;          // requester with highest priority next
  logic [1:0]        job_q;
  logic [7:0]        x0_q, w_q, col_q;
  logic [6:0]        y0_q, h_q, row_q;
  logic              key_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        drain_q;
  logic [2:0]        ack_q, done_q;
  logic              busy_q;
  pix_t              pipe_q [ROM_LATENCY];
  logic              draw_q;
  logic [7:0]        x_out_q;
  logic [6:0]        y_out_q;
  logic [23:0]       colour_q;

  logic [2:0]        rot;
  logic [1:0]        off;
  logic [2:0]        win_sum;
  logic              grant_vld;
  logic [1:0]        grant_idx;
  logic [7:0]        sel_x, sel_w;
  logic [6:0]        sel_y, sel_h;
  logic [ADDR_W-1:0] sel_base;
  logic              sel_key;
  logic              last_px;
  pix_t              head, tail;
  logic              visible;

  // Round-robin pick and mux of the winner's descriptor.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
    rot = bus.req;
    case (ptr_q)
      2'd1:    rot = {bus.req[0], bus.req[2], bus.req[1]};
      2'd2:    rot = {bus.req[1], bus.req[0], bus.req[2]};
      default: rot = bus.req;
    endcase
    grant_vld = |rot;
    off       = rot[0] ? 2'd0 : (rot[1] ? 2'd1 : 2'd2);
    win_sum   = {1'b0, ptr_q} + {1'b0, off};
    grant_idx = (win_sum >= 3'd3) ? 2'(win_sum - 3'd3) : win_sum[1:0];

    sel_x    = bus.req_x[7:0];
    sel_y    = bus.req_y[6:0];
    sel_w    = bus.req_w[7:0];
    sel_h    = bus.req_h[6:0];
    sel_base = bus.req_base[ADDR_W-1:0];
    sel_key  = bus.req_key[0];
    case (grant_idx)
      2'd1: begin
        sel_x    = bus.req_x[15:8];
        sel_y    = bus.req_y[13:7];
        sel_w    = bus.req_w[15:8];
        sel_h    = bus.req_h[13:7];
        sel_base = bus.req_base[2*ADDR_W-1:ADDR_W];
        sel_key  = bus.req_key[1];
      end
      2'd2: begin
        sel_x    = bus.req_x[23:16];
        sel_y    = bus.req_y[20:14];
        sel_w    = bus.req_w[23:16];
        sel_h    = bus.req_h[20:14];
        sel_base = bus.req_base[3*ADDR_W-1:2*ADDR_W];
        sel_key  = bus.req_key[2];
      end
      default: ;
    endcase
  end

  // Next-state logic of the job sequencer.
  always_comb begin
    last_px = (col_q == w_q - 8'd1) && (row_q == h_q - 7'd1);
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_vld) state_d = (sel_w == 8'd0 || sel_h == 7'd0) ? FIN : WALK;
      WALK:    if (last_px) state_d = DRAIN;
      DRAIN:   if (drain_q == 2'(ROM_LATENCY - 1)) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: sequential blocks use non-blocking assignments so every register samples pre-edge values.
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Job latch, raster walk counters, ROM address and handshake pulses.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr_q   <= 2'd0;
      job_q   <= 2'd0;
      x0_q    <= '0;
      y0_q    <= '0;
      w_q     <= '0;
      h_q     <= '0;
      key_q   <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
      addr_q  <= '0;
      drain_q <= '0;
      ack_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      ack_q  <= '0;
      done_q <= (state_q == FIN) ? (3'b001 << job_q) : 3'b000;
      // busy stays up through the done pulse unless a new job is granted then.
      if (state_q == IDLE && grant_vld) busy_q <= 1'b1;
      else if (done_q != 3'b000)        busy_q <= 1'b0;

      case (state_q)
        IDLE: if (grant_vld) begin
          job_q <= grant_idx;
          x0_q  <= sel_x;
          y0_q  <= sel_y;
          w_q   <= sel_w;
          h_q   <= sel_h;
          key_q <= sel_key;
          col_q <= '0;
          row_q <= '0;
          ack_q <= 3'b001 << grant_idx;
          ptr_q <= (grant_idx == 2'd2) ? 2'd0 : grant_idx + 2'd1;
          // Empty jobs leave the ROM address untouched.
          if (state_d == WALK) addr_q <= sel_base;
        end
        WALK: begin
          drain_q <= '0;
          if (!last_px) begin
            addr_q <= addr_q + 1'b1;
            if (col_q == w_q - 8'd1) begin
              col_q <= '0;
              row_q <= row_q + 7'd1;
            end else begin
              col_q <= col_q + 8'd1;
            end
          end
        end
        DRAIN: drain_q <= drain_q + 2'd1;
        default: ;
      endcase
    end
  end

  // Coordinates of the pixel whose address is on rom_addr this cycle.
  always_comb begin
    head.valid = (state_q == WALK);
    head.x     = {1'b0, x0_q} + {1'b0, col_q};
    head.y     = {1'b0, y0_q} + {1'b0, row_q};
    tail       = pipe_q[ROM_LATENCY-1];
    visible    = tail.valid && (tail.x < 9'(SCREEN_W)) && (tail.y < 8'(SCREEN_H)) &&
                 !(key_q && bus.rom_q == KEY_COLOUR);
  end

  // Alignment shift register: the tail entry matches the current rom_q.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // NOTE: this pipeline is a handful of flops, so it is reset to flush stale pixels; large memories would not be.
      for (int i = 0; i < ROM_LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= head;
      for (int i = 1; i < ROM_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  // Output register: strobe visible pixels, hold coordinates/colour otherwise.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      draw_q   <= 1'b0;
      x_out_q  <= '0;
      y_out_q  <= '0;
      colour_q <= '0;
    end else begin
      draw_q <= visible;
      if (visible) begin
        x_out_q  <= tail.x[7:0];
        y_out_q  <= tail.y[6:0];
        colour_q <= bus.rom_q;
      end
    end
  end

  assign bus.ack        = ack_q;
  assign bus.done       = done_q;
  assign bus.busy       = busy_q;
  assign bus.rom_addr   = addr_q;
  assign bus.x_out      = x_out_q;
  assign bus.y_out      = y_out_q;
  assign bus.colour_out = colour_q;
  assign bus.draw       = draw_q;

endmodule

// File: tb/tb_vga_blit_scheduler.sv
// Directed self-checking bench for vga_blit_scheduler (ROM_LATENCY = 1).
// A one-cycle colour ROM returns {6'h15, addr}, optionally forced to the key
// colour at one chosen address; a monitor logs draws, acks, dones and
// rom_addr changes per cycle, and the directed sequence checks those logs.
module tb_vga_blit_scheduler;

  localparam int ADDR_W = 18;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  vga_blit_scheduler_if #(.ADDR_W(ADDR_W)) bus ();

  vga_blit_scheduler #(
    .ROM_LATENCY(1), .SCREEN_W(160), .SCREEN_H(120), .ADDR_W(ADDR_W), .KEY_COLOUR(24'hFF00FF)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );

  // Stimulus descriptors, packed onto the bus.
  logic [2:0]        req_r;
  logic [7:0]        fx [3];
  logic [6:0]        fy [3];
  logic [7:0]        fw [3];
  logic [6:0]        fh [3];
  logic [ADDR_W-1:0] fb [3];
  logic              fk [3];

  assign bus.req      = req_r;
  assign bus.req_x    = {fx[2], fx[1], fx[0]};
  assign bus.req_y    = {fy[2], fy[1], fy[0]};
  assign bus.req_w    = {fw[2], fw[1], fw[0]};
  assign bus.req_h    = {fh[2], fh[1], fh[0]};
  assign bus.req_base = {fb[2], fb[1], fb[0]};
  assign bus.req_key  = {fk[2], fk[1], fk[0]};

  // Colour ROM model: one cycle of latency.
  logic              key_en;
  logic [ADDR_W-1:0] key_addr;

  function automatic logic [23:0] rom_word(input logic [ADDR_W-1:0] a);
    return {6'h15, a};
  endfunction

  always @(posedge clk)
    bus.rom_q <= (key_en && bus.rom_addr == key_addr) ? 24'hFF00FF : rom_word(bus.rom_addr);

  // Event logs filled by the monitor.
  typedef struct {
    int          cyc;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [23:0] c;
  } draw_ev_t;

  draw_ev_t          draws [$];
  int                ack_cyc [$];
  logic [2:0]        ack_val [$];
  int                done_cyc [$];
  logic [2:0]        done_val [$];
  int                addr_cyc [$];
  logic [ADDR_W-1:0] addr_val [$];
  int                busy_cycles;
  int                cyc;
  logic [ADDR_W-1:0] last_addr;

  int checks = 0;
  int errors = 0;

  // Monitor: samples outputs on the falling edge, away from the active edge.
  initial begin
    cyc = 0;
    busy_cycles = 0;
    last_addr = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.draw) draws.push_back('{cyc, bus.x_out, bus.y_out, bus.colour_out});
      if (bus.ack != 3'b000) begin ack_cyc.push_back(cyc); ack_val.push_back(bus.ack); end
      if (bus.done != 3'b000) begin done_cyc.push_back(cyc); done_val.push_back(bus.done); end
      if (bus.busy) busy_cycles++;
      if (bus.rom_addr != last_addr) begin addr_cyc.push_back(cyc); addr_val.push_back(bus.rom_addr); end
      last_addr = bus.rom_addr;
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    draws.delete();
    ack_cyc.delete();
    ack_val.delete();
    done_cyc.delete();
    done_val.delete();
    addr_cyc.delete();
    addr_val.delete();
    busy_cycles = 0;
  endtask

  task automatic setup(input int idx, input int x, input int y, input int w, input int h,
                       input int base, input int key);
    fx[idx] = 8'(x);
    fy[idx] = 7'(y);
    fw[idx] = 8'(w);
    fh[idx] = 7'(h);
    fb[idx] = ADDR_W'(base);
    fk[idx] = 1'(key);
  endtask

  // Wait (bounded) for an ack pulse; returns 0 if none arrives.
  task automatic wait_ack(output logic [2:0] a);
    a = 3'b000;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (bus.ack != 3'b000) begin
        a = bus.ack;
        break;
      end
    end
  endtask

  // Wait (bounded) for busy to fall, then let the monitor settle.
  task automatic wait_idle(input string tag);
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (!bus.busy) break;
    end
    check(tag, bus.busy, 1'b0);
    repeat (2) @(negedge clk);
  endtask

  task automatic run_job(input int idx, input string tag, output logic [2:0] a);
    clear_logs();
    req_r[idx] = 1'b1;
    wait_ack(a);
    req_r[idx] = 1'b0;
    wait_idle(tag);
  endtask

  task automatic reset_pulse();
    resetn = 1'b0;
    req_r  = 3'b000;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [2:0] a;
    logic [2:0] av [4];
    int         n;

    resetn   = 1'b0;
    req_r    = 3'b000;
    key_en   = 1'b0;
    key_addr = '0;
    for (int i = 0; i < 3; i++) setup(i, 0, 0, 0, 0, 0, 0);

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_ack", bus.ack, 3'b000);
    check("rst_done", bus.done, 3'b000);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_draw", bus.draw, 1'b0);
    check("rst_rom_addr", bus.rom_addr, 0);
    check("rst_x_out", bus.x_out, 0);
    check("rst_y_out", bus.y_out, 0);
    check("rst_colour_out", bus.colour_out, 0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // 1: 4x2 job at origin, base 100.
    setup(0, 0, 0, 4, 2, 100, 0);
    run_job(0, "t1_idle", a);
    check("t1_ack", a, 3'b001);
    check("t1_ack_count", ack_val.size(), 1);
    check("t1_addr_count", addr_val.size(), 8);
    for (int i = 0; i < 8 && i < addr_val.size(); i++) begin
      check("t1_addr", addr_val[i], 100 + i);
      check("t1_addr_cyc", addr_cyc[i], ack_cyc[0] + i);
    end
    check("t1_draw_count", draws.size(), 8);
    for (int i = 0; i < 8 && i < draws.size(); i++) begin
      check("t1_draw_x", draws[i].x, i % 4);
      check("t1_draw_y", draws[i].y, i / 4);
      check("t1_draw_colour", draws[i].c, rom_word(ADDR_W'(100 + i)));
      check("t1_draw_cyc", draws[i].cyc, ack_cyc[0] + 2 + i);
    end
    check("t1_done_count", done_val.size(), 1);
    check("t1_done", done_val[0], 3'b001);
    check("t1_done_latency", done_cyc[0] - ack_cyc[0], 10);
    check("t1_busy_cycles", busy_cycles, 11);

    // 2: all three requesting 1x1 jobs from a fresh reset -> grants 0,1,2,0.
    reset_pulse();
    setup(0, 1, 0, 1, 1, 200, 0);
    setup(1, 2, 0, 1, 1, 300, 0);
    setup(2, 3, 0, 1, 1, 400, 0);
    clear_logs();
    req_r = 3'b111;
    n = 0;
    for (int t = 0; t < 100 && n < 4; t++) begin
      @(negedge clk);
      if (bus.ack != 3'b000) begin
        av[n] = bus.ack;
        n++;
      end
    end
    req_r = 3'b000;
    wait_idle("t2_idle");
    check("t2_ack_seen", n, 4);
    check("t2_grant0", av[0], 3'b001);
    check("t2_grant1", av[1], 3'b010);
    check("t2_grant2", av[2], 3'b100);
    check("t2_grant3", av[3], 3'b001);
    check("t2_done_count", done_val.size(), 4);
    check("t2_done1", done_val[1], 3'b010);
    for (int i = 0; i < 3 && i + 1 < ack_cyc.size() && i < done_cyc.size(); i++)
      check("t2_done_to_ack", ack_cyc[i+1] - done_cyc[i], 1);
    check("t2_draw2_x", draws[2].x, 3);

    // 3: clipping at the bottom-right corner.
    setup(0, 158, 119, 4, 2, 0, 0);
    run_job(0, "t3_idle", a);
    check("t3_ack", a, 3'b001);
    check("t3_addr_count", addr_val.size(), 8);
    check("t3_addr_first", addr_val[0], 0);
    check("t3_addr_last", addr_val[7], 7);
    check("t3_draw_count", draws.size(), 2);
    check("t3_draw0_x", draws[0].x, 158);
    check("t3_draw0_y", draws[0].y, 119);
    check("t3_draw1_x", draws[1].x, 159);
    check("t3_draw1_colour", draws[1].c, rom_word(ADDR_W'(1)));
    check("t3_done", done_val[0], 3'b001);

    // 4: transparency, key colour at index 2 of a 4x1 job.
    key_en   = 1'b1;
    key_addr = ADDR_W'(52);
    setup(0, 10, 20, 4, 1, 50, 1);
    run_job(0, "t4a_idle", a);
    check("t4a_draw_count", draws.size(), 3);
    check("t4a_draw2_x", draws[2].x, 13);
    check("t4a_x_out_hold", bus.x_out, 13);
    setup(0, 10, 20, 4, 1, 50, 0);
    run_job(0, "t4b_idle", a);
    check("t4b_draw_count", draws.size(), 4);
    check("t4b_draw2_x", draws[2].x, 12);
    check("t4b_draw2_colour", draws[2].c, 24'hFF00FF);
    key_en = 1'b0;

    // 5: zero-width job.
    setup(0, 5, 5, 0, 5, 77, 0);
    run_job(0, "t5_idle", a);
    check("t5_ack", a, 3'b001);
    check("t5_addr_changes", addr_val.size(), 0);
    check("t5_draw_count", draws.size(), 0);
    check("t5_done_count", done_val.size(), 1);
    check("t5_done_gap", done_cyc[0] - ack_cyc[0], 1);
    check("t5_busy_cycles", busy_cycles, 2);

    // 6: asynchronous reset in the middle of a 10x10 job.
    setup(0, 0, 0, 10, 10, 1000, 0);
    clear_logs();
    req_r = 3'b001;
    wait_ack(a);
    req_r = 3'b000;
    check("t6_ack", a, 3'b001);
    repeat (5) @(negedge clk);
    check("t6_draw_before", bus.draw, 1'b1);
    #2 resetn = 1'b0;
    #1;
    check("t6_async_draw", bus.draw, 1'b0);
    check("t6_async_busy", bus.busy, 1'b0);
    check("t6_async_ack", bus.ack, 3'b000);
    check("t6_async_done", bus.done, 3'b000);
    check("t6_async_rom_addr", bus.rom_addr, 0);
    clear_logs();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (10) @(negedge clk);
    check("t6_no_done", done_val.size(), 0);
    check("t6_no_draw", draws.size(), 0);
    // After reset requester 0 has priority again.
    setup(0, 1, 1, 1, 1, 10, 0);
    setup(1, 2, 2, 1, 1, 20, 0);
    req_r = 3'b011;
    wait_ack(a);
    req_r = 3'b000;
    check("t6_req01_grant", a, 3'b001);
    wait_idle("t6a_idle");
    reset_pulse();
    req_r = 3'b010;
    wait_ack(a);
    req_r = 3'b000;
    check("t6_req1_grant", a, 3'b010);
    wait_idle("t6b_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_blit_scheduler.md
Name: vga_blit_scheduler

Overview:
- Sequences the single VGA pixel-write port between three rectangle-blit requesters: 0 = background image, 1 = score digits, 2 = overlay/sprite.
- Arbitrates round-robin and latches the winning job (position, size, ROM base).
- Walks the rectangle in raster order, issuing one colour-ROM address per cycle.
- Re-aligns x/y/plot with the ROM's registered output, then drives x_out/y_out/colour_out/draw toward the VGA adapter.

Parameters:
ROM_LATENCY, 1, cycles from rom_addr to valid rom_q (1..4)
SCREEN_W, 160, pixels with x >= SCREEN_W are clipped
SCREEN_H, 120, pixels with y >= SCREEN_H are clipped
ADDR_W, 18, ROM address width
KEY_COLOUR, 24'hFF00FF, transparent colour when job key bit set

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
req  in  3  per-requester job request, level, held until ack
req_x  in  24  packed 3x8 top-left x
req_y  in  21  packed 3x7 top-left y
req_w  in  24  packed 3x8 width (0..255)
req_h  in  21  packed 3x7 height (0..127)
req_base  in  3*ADDR_W  packed ROM start address
req_key  in  3  packed transparency enable
ack  out  3  one-hot one-cycle pulse, job accepted
done  out  3  one-hot one-cycle pulse, job fully written
busy  out  1  high from acceptance through the done cycle
rom_addr  out  ADDR_W  colour ROM address
rom_q  in  24  colour ROM data
x_out  out  8  pixel x
y_out  out  7  pixel y
colour_out  out  24  pixel colour
draw  out  1  pixel write strobe

Behaviour:
Reset:
- resetn low at any time asynchronously clears state to IDLE.
- ack, done, busy, draw = 0; rom_addr, x_out, y_out, colour_out = 0.
- Alignment pipeline flushed; RR pointer = 0 (req0 highest priority).
- Reset mid-job abandons the job with no done pulse.

States: IDLE, WALK, DRAIN, FIN.

IDLE:
- If any req bit is set, grant by round-robin starting at (last_grant+1) mod 3.
- On that edge: latch the winner's fields, set ack[winner]=1 for exactly one cycle, busy=1, update last_grant.
- Next state: WALK, or FIN if w==0 or h==0.

WALK:
- Each cycle issue rom_addr = base + linear index (one increment per pixel, mod 2^ADDR_W; row stride = w).
- Push (x0+col, y0+row, valid) into a ROM_LATENCY-deep shift register.
- Raster order: col 0..w-1 then row+1. After pixel (w-1, h-1) is issued, go to DRAIN.

DRAIN:
- Hold ROM_LATENCY cycles until the pipeline empties, then go to FIN.

FIN:
- done[job]=1 for one cycle; busy drops the following cycle; go to IDLE.
- Arbitration resumes in the cycle after FIN, so there is always at least one idle cycle between jobs.

Output stage:
- Registered: draw is high in the cycle rom_q for that pixel is valid; x_out/y_out/colour_out change together with it.
- Coordinates are computed 9-bit/8-bit wide. draw is suppressed when x >= SCREEN_W, y >= SCREEN_H, or (key set and rom_q == KEY_COLOUR).
- The address still advances for suppressed pixels.
- When draw = 0, x_out/y_out/colour_out hold their last value.

Throughput and latency:
- w*h pixels take w*h WALK cycles plus ROM_LATENCY.
- From the ack edge, the first draw occurs ROM_LATENCY+1 cycles later.

Request rules:
- Latched fields are immune to input changes after ack.
- Dropping req mid-job does not abort the job.
- A req still high after done is treated as a new job.
- A req asserted during busy waits.
- Simultaneous requests are resolved by RR only.

Test Plan:
1. Reset, req=001, x=0,y=0,w=4,h=2,base=100, ROM_LATENCY=1 -> ack=001 one cycle; rom_addr 100..107 on consecutive cycles; draw 8 cycles with (x,y) = (0,0)..(3,0),(0,1)..(3,1) and colour = rom_q; done=001 once; busy drops.
2. req=111 held constant, each w=1,h=1 -> grants in order 0,1,2,0; every done precedes the next ack by at least 1 cycle.
3. Clip: x=158,y=119,w=4,h=2,base=0 -> rom_addr 0..7 issued; draw only for (158,119),(159,119); done still pulses.
4. Transparency: key=1, rom_q=FF00FF at index 2 of a 4x1 job -> 3 draw pulses, index-2 pixel skipped; repeat with key=0 -> 4 pulses.
5. w=0,h=5 -> ack, no rom_addr change, no draw, done the cycle after ack's FIN; busy high 2 cycles.
6. resetn pulsed low in WALK of a 10x10 job -> draw, busy, ack, done = 0 immediately (asynchronous); no done; a fresh req1 after release is granted first only if req0 is low.
